// File: rtl/truth_table_stepper_pkg.sv
// Shared definitions for the 2-input gate truth-table stepper: state encoding,
// vector count, default expected truth tables and the result payload.
package truth_table_stepper_pkg;

  localparam int unsigned TT_VECTORS = 4;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned ERR_W      = 3;

  // Bit i is the expected output for vector i = {x,y}
  localparam logic [TT_VECTORS-1:0] TT_AND_NOT_A = 4'b0010;
  localparam logic [TT_VECTORS-1:0] TT_OR        = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } tt_state_e;

  typedef struct packed {
    logic                  pass;
    logic [ERR_W-1:0]      err_count;
    logic [TT_VECTORS-1:0] err_mask;
  } tt_result_t;

  function automatic logic vec_mismatch(input logic a_act, input logic b_act,
                                        input logic a_exp, input logic b_exp);
    return (a_act != a_exp) || (b_act != b_exp);
  endfunction

endpackage

// File: rtl/truth_table_stepper_settle_timer.sv
// Settle-window counter: cleared by load_i, advances while en_i, and flags the
// last cycle of the window combinationally on expire_c.
module truth_table_stepper_settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expire_c
);

  localparam int unsigned       CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  TERM  = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expire_c = (cnt_q == TERM);

  // Counter holds at terminal count until the next reload
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/truth_table_stepper.sv
// Clocked stimulus/check sequencer for the 2-input gate exercise: steps {x,y}
// through 00..11, samples a_in/b_in after each settle window and scores them.
module truth_table_stepper
  import truth_table_stepper_pkg::*;
#(
  parameter int unsigned           SETTLE_CYCLES = 1,
  parameter logic [TT_VECTORS-1:0] EXP_A         = TT_AND_NOT_A,
  parameter logic [TT_VECTORS-1:0] EXP_B         = TT_OR
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  a_in,
  input  logic                  b_in,
  output logic                  x,
  output logic                  y,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_count,
  output logic [TT_VECTORS-1:0] err_mask
);

  tt_state_e        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  tt_result_t       res_q, res_d;

  logic expire_c;
  logic load_c;
  logic last_c;
  logic mismatch_c;

  assign last_c     = (idx_q == IDX_W'(TT_VECTORS - 1));
  assign mismatch_c = vec_mismatch(a_in, b_in, EXP_A[idx_q], EXP_B[idx_q]);

  truth_table_stepper_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load_c),
    .en_i     (state_q == ST_SETTLE),
    .expire_c (expire_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (start)    state_d = ST_SETTLE;
      ST_SETTLE:        if (expire_c) state_d = ST_SAMPLE;
      ST_SAMPLE:        state_d = last_c ? ST_DONE : ST_SETTLE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Datapath next values; x/y follow idx so they move only on start and SAMPLE edges
  always_comb begin
    idx_d  = idx_q;
    busy_d = busy_q;
    done_d = done_q;
    res_d  = res_q;
    load_c = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          idx_d  = '0;
          busy_d = 1'b1;
          done_d = 1'b0;
          res_d  = '0;
          load_c = 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (mismatch_c) begin
          res_d.err_mask[idx_q] = 1'b1;
          res_d.err_count       = res_q.err_count + ERR_W'(1);
        end
        if (last_c) begin
          busy_d     = 1'b0;
          done_d     = 1'b1;
          res_d.pass = (res_d.err_count == '0);
        end else begin
          idx_d  = idx_q + IDX_W'(1);
          load_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      res_q  <= '0;
    end else begin
      idx_q  <= idx_d;
      busy_q <= busy_d;
      done_q <= done_d;
      res_q  <= res_d;
    end
  end

  assign x         = idx_q[1];
  assign y         = idx_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = res_q.pass;
  assign err_count = res_q.err_count;
  assign err_mask  = res_q.err_mask;

endmodule
